// File: rtl/bayer_pkg.sv
// Shared types and constants for the Bayer quad converter: output modes,
// quad layouts and the integer luma weights.
package bayer_pkg;

    typedef enum logic [1:0] {
        MODE_RGB       = 2'd0,
        MODE_GREY_AVG  = 2'd1,
        MODE_GREY_LUMA = 2'd2,
        MODE_RAW       = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        PAT_GRBG = 2'd0,
        PAT_RGGB = 2'd1,
        PAT_BGGR = 2'd2,
        PAT_GBRG = 2'd3
    } pattern_e;

    // Y = (5R + 9G + 2B) >> 4; weights sum to 16 so full scale maps to full scale
    localparam int unsigned LUMA_R     = 5;
    localparam int unsigned LUMA_G     = 9;
    localparam int unsigned LUMA_B     = 2;
    localparam int unsigned LUMA_SHIFT = 4;

endpackage

// File: rtl/bayer_quad_convert_if.sv
// Pixel-stream bundle between the CCD capture unit and the quad converter:
// raw pixel in with coordinates and mode request, half-resolution colour out.
interface bayer_quad_convert_if #(
    parameter int DATA_W = 12,
    parameter int X_W    = 11,
    parameter int Y_W    = 11
);
    logic [X_W-1:0]    iX_Cont;
    logic [Y_W-1:0]    iY_Cont;
    logic [DATA_W-1:0] iDATA;
    logic              iDVAL;
    logic [1:0]        iMODE;
    logic [DATA_W-1:0] oRed;
    logic [DATA_W-1:0] oGreen;
    logic [DATA_W-1:0] oBlue;
    logic [X_W-1:0]    oX_Cont;
    logic [Y_W-1:0]    oY_Cont;
    logic              oDVAL;

    modport master (
        output iX_Cont, iY_Cont, iDATA, iDVAL, iMODE,
        input  oRed, oGreen, oBlue, oX_Cont, oY_Cont, oDVAL
    );

    modport slave (
        input  iX_Cont, iY_Cont, iDATA, iDVAL, iMODE,
        output oRed, oGreen, oBlue, oX_Cont, oY_Cont, oDVAL
    );
endinterface

// File: rtl/bayer_line_buf.sv
// One-line pixel store: simple dual-port RAM, synchronous read-before-write.
// The read register holds its value between enabled cycles.
module bayer_line_buf #(
    parameter int DEPTH = 1280,
    parameter int WIDTH = 12,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             rdEn,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end
endmodule

// File: rtl/bayer_quad_convert.sv
// Raw Bayer stream to half-resolution RGB/grey, one output per 2x2 quad, mode
// latched at frame start. Define FRAME_MAX_EN to add the oFrameMax port.
module bayer_quad_convert
    import bayer_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int X_W       = 11,
    parameter int Y_W       = 11,
    parameter int LINE_W    = 1280,
    parameter int BAYER_PAT = 0
) (
    input  logic iCLK,
    input  logic iRST,
    bayer_quad_convert_if.slave bus
`ifdef FRAME_MAX_EN
    ,
    output logic [DATA_W-1:0] oFrameMax
`endif
);
    localparam int          AW       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [X_W:0] LINE_LIM = (X_W + 1)'(LINE_W);
    localparam pattern_e    PAT      = pattern_e'(2'(BAYER_PAT));

    logic              accept, frameStart, quadDone;
    logic [AW-1:0]     bufAddr;
    logic [DATA_W-1:0] rdData, curLinePx;
    logic              linesOk;
    mode_e             modeReg;

    logic              s1Valid;
    logic [DATA_W-1:0] s1P00, s1P10, s1P11;
    logic [X_W-1:0]    s1X;
    logic [Y_W-1:0]    s1Y;
    mode_e             s1Mode;

    logic [DATA_W-1:0] r, g1, g2, b, gAvg, nRed, nGreen, nBlue;
    logic [DATA_W:0]   gSum;
    logic [DATA_W+1:0] avgSum;
    logic [DATA_W+3:0] lumaSum;

    assign accept     = bus.iDVAL && ({1'b0, bus.iX_Cont} < LINE_LIM);
    assign frameStart = accept && (bus.iX_Cont == '0) && (bus.iY_Cont == '0);
    assign quadDone   = accept && bus.iX_Cont[0] && bus.iY_Cont[0] && linesOk;
    assign bufAddr    = AW'(bus.iX_Cont);

    bayer_line_buf #(.DEPTH(LINE_W), .WIDTH(DATA_W), .AW(AW)) lineBuf (
        .clk    (iCLK),
        .rdEn   (accept),
        .rdAddr (bufAddr),
        .rdData (rdData),
        .wrEn   (accept),
        .wrAddr (bufAddr),
        .wrData (bus.iDATA)
    );

    // The held RAM output is the previous-line previous-pixel value (P00) on an
    // accepted cycle; P01 arrives from the same port during S1, so the channel
    // map and G1+G2 are formed at the S2 input.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            linesOk   <= 1'b0;
            modeReg   <= MODE_RGB;
            curLinePx <= '0;
            s1Valid   <= 1'b0;
            s1P00     <= '0;
            s1P10     <= '0;
            s1P11     <= '0;
            s1X       <= '0;
            s1Y       <= '0;
            s1Mode    <= MODE_RGB;
        end else begin
            s1Valid <= quadDone;
            if (accept) begin
                curLinePx <= bus.iDATA;
                if (!bus.iY_Cont[0]) linesOk <= 1'b1;
                if (frameStart) modeReg <= mode_e'(bus.iMODE);
            end
            if (quadDone) begin
                s1P00  <= rdData;
                s1P10  <= curLinePx;
                s1P11  <= bus.iDATA;
                s1X    <= bus.iX_Cont >> 1;
                s1Y    <= bus.iY_Cont >> 1;
                s1Mode <= modeReg;
            end
        end
    end

    always_comb begin
        r  = '0;
        g1 = '0;
        g2 = '0;
        b  = '0;
        case (PAT)
            PAT_GRBG: begin g1 = s1P00; r  = rdData; b  = s1P10; g2 = s1P11; end
            PAT_RGGB: begin r  = s1P00; g1 = rdData; g2 = s1P10; b  = s1P11; end
            PAT_BGGR: begin b  = s1P00; g1 = rdData; g2 = s1P10; r  = s1P11; end
            default:  begin g1 = s1P00; b  = rdData; r  = s1P10; g2 = s1P11; end
        endcase

        gSum    = {1'b0, g1} + {1'b0, g2};
        gAvg    = DATA_W'(gSum >> 1);
        avgSum  = (DATA_W + 2)'(r) + (DATA_W + 2)'(g1) + (DATA_W + 2)'(g2) + (DATA_W + 2)'(b);
        lumaSum = (DATA_W + 4)'(LUMA_R) * (DATA_W + 4)'(r)
                + (DATA_W + 4)'(LUMA_G) * (DATA_W + 4)'(gAvg)
                + (DATA_W + 4)'(LUMA_B) * (DATA_W + 4)'(b);

        nRed   = r;
        nGreen = gAvg;
        nBlue  = b;
        case (s1Mode)
            MODE_GREY_AVG: begin
                nRed   = DATA_W'(avgSum >> 2);
                nGreen = nRed;
                nBlue  = nRed;
            end
            MODE_GREY_LUMA: begin
                nRed   = DATA_W'(lumaSum >> LUMA_SHIFT);
                nGreen = nRed;
                nBlue  = nRed;
            end
            MODE_RAW: begin
                nRed   = s1P11;
                nGreen = s1P11;
                nBlue  = s1P11;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            bus.oDVAL   <= 1'b0;
            bus.oRed    <= '0;
            bus.oGreen  <= '0;
            bus.oBlue   <= '0;
            bus.oX_Cont <= '0;
            bus.oY_Cont <= '0;
        end else begin
            bus.oDVAL <= s1Valid;
            if (s1Valid) begin
                bus.oRed    <= nRed;
                bus.oGreen  <= nGreen;
                bus.oBlue   <= nBlue;
                bus.oX_Cont <= s1X;
                bus.oY_Cont <= s1Y;
            end
        end
    end

`ifdef FRAME_MAX_EN
    logic [DATA_W-1:0] runMax;
    logic [DATA_W-1:0] maxWithNew;

    assign maxWithNew = (s1Valid && (nGreen > runMax)) ? nGreen : runMax;

    // A quad leaving S2 in the frame-start cycle belongs to the closing frame.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            runMax    <= '0;
            oFrameMax <= '0;
        end else if (frameStart) begin
            oFrameMax <= maxWithNew;
            runMax    <= '0;
        end else begin
            runMax <= maxWithNew;
        end
    end
`endif

endmodule

// File: tb/tb_bayer_quad_convert.sv
// Directed bench for bayer_quad_convert (GRBG, default sizes); exercises the
// FRAME_MAX_EN port when that macro is defined.
module tb_bayer_quad_convert;
    localparam int DATA_W = 12;
    localparam int X_W    = 11;
    localparam int Y_W    = 11;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [11:0] r;
        logic [11:0] g;
        logic [11:0] b;
    } outRec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bayer_quad_convert_if #(.DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W)) bus ();
`ifdef FRAME_MAX_EN
    logic [DATA_W-1:0] frameMax;
`endif

    bayer_quad_convert #(
        .DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W), .LINE_W(1280), .BAYER_PAT(0)
    ) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
`ifdef FRAME_MAX_EN
        ,
        .oFrameMax (frameMax)
`endif
    );

    int nCompared   = 0;
    int nMismatched = 0;
    outRec_t outQ[$];
    outRec_t expQ[$];
    logic [11:0] fr [4][8];

    always @(negedge clk) begin
        if (bus.oDVAL === 1'b1)
            outQ.push_back({bus.oX_Cont, bus.oY_Cont, bus.oRed, bus.oGreen, bus.oBlue});
    end

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sendPix(input int x, input int y, input int d, input int m);
        @(negedge clk);
        bus.iDVAL   = 1'b1;
        bus.iX_Cont = 11'(x);
        bus.iY_Cont = 11'(y);
        bus.iDATA   = 12'(d);
        bus.iMODE   = 2'(m);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.iDVAL = 1'b0;
        end
    endtask

    function automatic logic [63:0] outNow();
        return 64'({bus.oX_Cont, bus.oY_Cont, bus.oRed, bus.oGreen, bus.oBlue});
    endfunction

    // GRBG reference: G1=P00, R=P01, B=P10, G2=P11
    function automatic outRec_t quadRef(input int x, input int y, input int p00, input int p01,
                                        input int p10, input int p11, input int m);
        outRec_t o;
        int g, yv;
        g = (p00 + p11) / 2;
        o.x = 11'(x / 2);
        o.y = 11'(y / 2);
        case (m)
            0: begin o.r = 12'(p01); o.g = 12'(g); o.b = 12'(p10); end
            1: begin yv = (p01 + p00 + p11 + p10) / 4; o.r = 12'(yv); o.g = 12'(yv); o.b = 12'(yv); end
            2: begin yv = (5 * p01 + 9 * g + 2 * p10) / 16; o.r = 12'(yv); o.g = 12'(yv); o.b = 12'(yv); end
            default: begin o.r = 12'(p11); o.g = 12'(p11); o.b = 12'(p11); end
        endcase
        return o;
    endfunction

    task automatic fillFrame(input int seed);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                fr[y][x] = 12'((x * 263 + y * 977 + seed * 151 + x * y * 31) % 4096);
    endtask

    task automatic buildExp(input int m);
        expQ.delete();
        for (int y = 1; y < 4; y += 2)
            for (int x = 1; x < 8; x += 2)
                expQ.push_back(quadRef(x, y, int'(fr[y-1][x-1]), int'(fr[y-1][x]),
                                       int'(fr[y][x-1]), int'(fr[y][x]), m));
    endtask

    task automatic sendFrame(input int m0, input bit toggle, input bit gaps);
        int idx = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                sendPix(x, y, int'(fr[y][x]), toggle ? (m0 + idx / 5) % 4 : m0);
                idx++;
                if (gaps) idle($urandom_range(0, 3));
            end
            if (gaps) begin
                sendPix(1281, y, 12'hFFF, 3);
                sendPix(2047, y | 1, 12'h123, 0);
            end
        end
        idle(4);
    endtask

    task automatic compareStream(input string tag);
        int n;
        checkEq({tag, ".count"}, 64'(outQ.size()), 64'(expQ.size()));
        n = (outQ.size() < expQ.size()) ? outQ.size() : expQ.size();
        for (int i = 0; i < n; i++)
            checkEq($sformatf("%s[%0d]", tag, i), 64'(outQ[i]), 64'(expQ[i]));
        outQ.delete();
    endtask

    task automatic runQuad(input string tag, input int p00, input int p01, input int p10,
                           input int p11, input int m, input int eR, input int eG, input int eB);
        outRec_t e;
        outQ.delete();
        sendPix(0, 0, p00, m);
        sendPix(1, 0, p01, m);
        sendPix(0, 1, p10, m);
        sendPix(1, 1, p11, m);
        idle(4);
        e = '{x: 11'd0, y: 11'd0, r: 12'(eR), g: 12'(eG), b: 12'(eB)};
        checkEq({tag, ".count"}, 64'(outQ.size()), 64'd1);
        if (outQ.size() > 0) checkEq({tag, ".px"}, 64'(outQ[0]), 64'(e));
        outQ.delete();
    endtask

    initial begin
        bus.iDVAL = 1'b0; bus.iX_Cont = '0; bus.iY_Cont = '0; bus.iDATA = '0; bus.iMODE = '0;
        repeat (3) @(negedge clk);
        checkEq("rst.dval", 64'(bus.oDVAL), 64'd0);
        checkEq("rst.out", outNow(), 64'd0);
`ifdef FRAME_MAX_EN
        checkEq("rst.fmax", 64'(frameMax), 64'd0);
`endif
        rst = 1'b0;
        idle(2);

        // Latency and hold on the reference quad
        outQ.delete();
        sendPix(0, 0, 12'h100, 0);
        sendPix(1, 0, 12'h200, 0);
        sendPix(0, 1, 12'h040, 0);
        sendPix(1, 1, 12'h300, 0);
        idle(1);
        checkEq("lat.t1", 64'(bus.oDVAL), 64'd0);
        idle(1);
        checkEq("lat.t2", 64'(bus.oDVAL), 64'd1);
        checkEq("lat.px", outNow(), 64'({11'd0, 11'd0, 12'h200, 12'h200, 12'h040}));
        idle(1);
        checkEq("lat.t3", 64'(bus.oDVAL), 64'd0);
        checkEq("hold.px", outNow(), 64'({11'd0, 11'd0, 12'h200, 12'h200, 12'h040}));
        idle(2);
        checkEq("lat.pulses", 64'(outQ.size()), 64'd1);

        runQuad("m1", 12'h100, 12'h200, 12'h040, 12'h300, 1, 12'h190, 12'h190, 12'h190);
        runQuad("m2", 12'h100, 12'h200, 12'h040, 12'h300, 2, 12'h1C8, 12'h1C8, 12'h1C8);
        runQuad("m2full", 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 2, 12'hFFF, 12'hFFF, 12'hFFF);
        runQuad("m3", 12'h100, 12'h200, 12'h040, 12'h300, 3, 12'h300, 12'h300, 12'h300);

        // Mode follows the (0,0) capture only, despite toggling mid-frame
        outQ.delete();
        fillFrame(1); buildExp(1); sendFrame(1, 1'b1, 1'b0); compareStream("latchA");
        fillFrame(2); buildExp(2); sendFrame(2, 1'b1, 1'b0); compareStream("latchB");

        // Idle gaps and out-of-range columns must not disturb the stream
        fillFrame(3); buildExp(0); sendFrame(0, 1'b0, 1'b0); compareStream("nogap");
        buildExp(0); sendFrame(0, 1'b0, 1'b1); compareStream("gaps");

        // Reset with a quad in flight
        runQuad("pre", 12'h100, 12'h200, 12'h040, 12'h300, 2, 12'h1C8, 12'h1C8, 12'h1C8);
        sendPix(0, 0, 12'h111, 2);
        sendPix(1, 0, 12'h222, 2);
        sendPix(0, 1, 12'h333, 2);
        sendPix(1, 1, 12'h444, 2);
        @(negedge clk);
        rst = 1'b1;
        bus.iDVAL = 1'b0;
        #1;
        checkEq("mrst.dval", 64'(bus.oDVAL), 64'd0);
        checkEq("mrst.out", outNow(), 64'd0);
        idle(3);
        rst = 1'b0;
        checkEq("mrst.lost", 64'(outQ.size()), 64'd0);
        for (int x = 0; x < 4; x++) sendPix(x, 1, 12'h700 + x, 2);
        for (int x = 0; x < 4; x++) sendPix(x, 3, 12'h710 + x, 2);
        idle(4);
        checkEq("mrst.oddonly", 64'(outQ.size()), 64'd0);
        sendPix(0, 2, 12'h010, 2);
        sendPix(1, 2, 12'h020, 2);
        sendPix(0, 3, 12'h030, 2);
        sendPix(1, 3, 12'h050, 2);
        idle(4);
        checkEq("mrst.count", 64'(outQ.size()), 64'd1);
        if (outQ.size() > 0)
            checkEq("mrst.px", 64'(outQ[0]), 64'({11'd0, 11'd1, 12'h020, 12'h030, 12'h030}));
        outQ.delete();

`ifdef FRAME_MAX_EN
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                fr[y][x] = 12'(x + y * 8);
        fr[0][2] = 12'hABC; fr[0][3] = 12'hABC; fr[1][2] = 12'hABC; fr[1][3] = 12'hABC;
        sendFrame(1, 1'b0, 1'b0);
        sendPix(0, 0, 12'h001, 1);
        idle(1);
        checkEq("fmax", 64'(frameMax), 64'hABC);
        idle(2);
        outQ.delete();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        nMismatched++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
